// File: rtl/pipe_pkg.sv
// Shared types for the pipeline hazard controller: FSM encoding, register-zero
// constant and the bundle of per-stage enable/clear controls.
package pipe_pkg;

   typedef enum logic {
      RUN      = 1'b0,
      MDU_WAIT = 1'b1
   } state_e;

   localparam logic [4:0] REG_ZERO = 5'd0;

   typedef struct packed {
      logic pc_en;
      logic if_id_en;
      logic if_id_clr;
      logic id_ex_en;
      logic id_ex_clr;
      logic ex_mem_en;
      logic ex_mem_clr;
      logic mem_wb_en;
      logic mem_wb_clr;
   } ctrl_t;

   // Free-running pipeline: everything advances, nothing is cleared.
   function automatic ctrl_t ctrl_run();
      ctrl_t c;
      c            = '0;
      c.pc_en      = 1'b1;
      c.if_id_en   = 1'b1;
      c.id_ex_en   = 1'b1;
      c.ex_mem_en  = 1'b1;
      c.mem_wb_en  = 1'b1;
      return c;
   endfunction

   // Front end and EX frozen; a bubble is pushed into WB.
   function automatic ctrl_t ctrl_mem_stall();
      ctrl_t c;
      c            = '0;
      c.mem_wb_en  = 1'b1;
      c.mem_wb_clr = 1'b1;
      return c;
   endfunction

   // EX held by the MDU; a bubble is pushed into MEM.
   function automatic ctrl_t ctrl_mdu_stall();
      ctrl_t c;
      c            = '0;
      c.ex_mem_clr = 1'b1;
      c.mem_wb_en  = 1'b1;
      return c;
   endfunction

endpackage

// File: rtl/pipe_hazard_ctrl_hazard_detect.sv
// Load-use detector: the load in EX writes a register the ID instruction reads.
module hazard_detect
   import pipe_pkg::*;
(
   input  logic       ex_mem_read,
   input  logic [4:0] ex_wAddr,
   input  logic [4:0] id_rs,
   input  logic [4:0] id_rt,
   input  logic       id_uses_rt,
   output logic       load_use
);

   // r0 is hardwired, so a load targeting it never creates a dependency.
   assign load_use = ex_mem_read && (ex_wAddr != REG_ZERO) &&
                     ((ex_wAddr == id_rs) || (id_uses_rt && (ex_wAddr == id_rt)));

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Central stall/flush controller for the 5-stage pipeline: priority mux over
// memory wait, MDU occupancy, taken branch and load-use, plus perf/timeout state.
module pipe_hazard_ctrl
   import pipe_pkg::*;
#(
   parameter int MDU_LAT = 4,
   parameter int MEM_TO  = 64
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [4:0]  id_rs,
   input  logic [4:0]  id_rt,
   input  logic        id_uses_rt,
   input  logic        ex_mem_read,
   input  logic [4:0]  ex_wAddr,
   input  logic        ex_branch_taken,
   input  logic        ex_mdu_start,
   input  logic        dmem_req,
   input  logic        dmem_ack,
   output logic        pc_en,
   output logic        if_id_en,
   output logic        if_id_clr,
   output logic        id_ex_en,
   output logic        id_ex_clr,
   output logic        ex_mem_en,
   output logic        ex_mem_clr,
   output logic        mem_wb_en,
   output logic        mem_wb_clr,
   output logic        mdu_busy,
   output logic        mem_err,
   output logic [31:0] stall_cnt
);

   localparam int         TO_W         = $clog2(MEM_TO + 1);
   localparam logic [7:0] MDU_CNT_LOAD = 8'(MDU_LAT - 2);

   state_e            state_q, state_d;
   logic [7:0]        mdu_cnt_q, mdu_cnt_d;
   logic [TO_W-1:0]   to_cnt_q, to_cnt_d;
   logic              mem_err_q, mem_err_d;
   logic [31:0]       stall_cnt_q, stall_cnt_d;
   ctrl_t             ctrl;
   logic              load_use;
   logic              mem_stall;

   hazard_detect u_hazard_detect (
      .ex_mem_read (ex_mem_read),
      .ex_wAddr    (ex_wAddr),
      .id_rs       (id_rs),
      .id_rt       (id_rt),
      .id_uses_rt  (id_uses_rt),
      .load_use    (load_use)
   );

   assign mem_stall = dmem_req && !dmem_ack;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q     <= RUN;
         mdu_cnt_q   <= '0;
         to_cnt_q    <= '0;
         mem_err_q   <= 1'b0;
         stall_cnt_q <= '0;
      end else begin
         state_q     <= state_d;
         mdu_cnt_q   <= mdu_cnt_d;
         to_cnt_q    <= to_cnt_d;
         mem_err_q   <= mem_err_d;
         stall_cnt_q <= stall_cnt_d;
      end
   end

   // FSM next state and output priority mux.
   always_comb begin
      state_d   = state_q;
      mdu_cnt_d = mdu_cnt_q;
      ctrl      = ctrl_run();
      if (mem_stall) begin
         ctrl = ctrl_mem_stall();
      end else if (state_q == MDU_WAIT) begin
         // At count zero this is the release cycle: the departing MDU op still
         // drives ex_mdu_start, so it must not retrigger.
         if (mdu_cnt_q != 8'd0) begin
            ctrl      = ctrl_mdu_stall();
            mdu_cnt_d = mdu_cnt_q - 8'd1;
         end else begin
            state_d = RUN;
         end
      end else if (ex_mdu_start) begin
         ctrl      = ctrl_mdu_stall();
         mdu_cnt_d = MDU_CNT_LOAD;
         state_d   = MDU_WAIT;
      end else if (ex_branch_taken) begin
         ctrl.if_id_clr = 1'b1;
         ctrl.id_ex_clr = 1'b1;
      end else if (load_use) begin
         ctrl.pc_en     = 1'b0;
         ctrl.if_id_en  = 1'b0;
         ctrl.id_ex_clr = 1'b1;
      end
      if (!rst) begin
         ctrl = '0;
      end
   end

   // Timeout counter saturates at MEM_TO so a very long stall cannot wrap it.
   always_comb begin
      to_cnt_d    = '0;
      mem_err_d   = mem_err_q;
      stall_cnt_d = stall_cnt_q;
      if (mem_stall) begin
         to_cnt_d = to_cnt_q;
         if (to_cnt_q != TO_W'(MEM_TO)) begin
            to_cnt_d = to_cnt_q + TO_W'(1);
         end
         if (to_cnt_q >= TO_W'(MEM_TO - 1)) begin
            mem_err_d = 1'b1;
         end
      end
      if (!ctrl.pc_en) begin
         stall_cnt_d = stall_cnt_q + 32'd1;
      end
   end

   assign pc_en      = ctrl.pc_en;
   assign if_id_en   = ctrl.if_id_en;
   assign if_id_clr  = ctrl.if_id_clr;
   assign id_ex_en   = ctrl.id_ex_en;
   assign id_ex_clr  = ctrl.id_ex_clr;
   assign ex_mem_en  = ctrl.ex_mem_en;
   assign ex_mem_clr = ctrl.ex_mem_clr;
   assign mem_wb_en  = ctrl.mem_wb_en;
   assign mem_wb_clr = ctrl.mem_wb_clr;
   assign mdu_busy   = (state_q == MDU_WAIT);
   assign mem_err    = mem_err_q;
   assign stall_cnt  = stall_cnt_q;

endmodule
